pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage. It owns the architectural fetch PC register and advances it sequentially under a fetch handshake. It applies prioritised redirects from execute (branch, JALR, trap), detects misaligned targets, and emits a flush pulse. An optional return-address stack (RAS) is included for call/return prediction.

---
 rtl/pc_gen_if.sv | 36 +++
 rtl/pc_gen.sv | 199 +++++++++++++++++++
 tb/tb_pc_gen.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch/execute-side signal bundle for the program-counter generator.
// The "slave" modport is taken by pc_gen; the "master" modport by whatever
// drives fetch handshakes, redirects and RAS updates.
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            fetch_ready;
    logic            stall;
    logic            redirect_valid;
    logic [1:0]      redirect_src;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] trap_vector;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid;
    logic            flush_o;
    logic            misalign_o;
    logic            fault_o;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

    modport master (
        output fetch_ready, stall, redirect_valid, redirect_src, ex_pc, imm,
               rs1_data, trap_vector, ras_push, ras_pop,
        input  pc_o, pc_valid, flush_o, misalign_o, fault_o, ras_top, ras_empty
    );

    modport slave (
        input  fetch_ready, stall, redirect_valid, redirect_src, ex_pc, imm,
               rs1_data, trap_vector, ras_push, ras_pop,
        output pc_o, pc_valid, flush_o, misalign_o, fault_o, ras_top, ras_empty
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Owns the fetch PC, advances it by 4 on accepted fetches, applies execute
// redirects (trap > branch/JALR > stall > sequential), traps misaligned
// targets into a FAULT state, and optionally predicts returns with a RAS.
// Optional feature: define PC_GEN_RAS_EN to build the return-address stack.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    pc_gen_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic            pc_valid_q;
    logic            flush_q;
    logic            misalign_q;
    logic            fault_q;

    logic            is_trap;
    logic            is_jump;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            target_misaligned;

    assign is_trap = bus.redirect_valid && (bus.redirect_src == 2'b11);
    assign is_jump = bus.redirect_valid &&
                     ((bus.redirect_src == 2'b01) || (bus.redirect_src == 2'b10));
    assign jalr_sum = bus.rs1_data + bus.imm;

    // Redirect target for branch (ex_pc+imm) or JALR ((rs1+imm) with bit0 cleared).
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        target = bus.ex_pc + bus.imm;
        if (bus.redirect_src == 2'b10) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end
    end

    assign target_misaligned = (target[1:0] != 2'b00);

    // Control FSM with registered PC and status outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            unique case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_valid_q <= 1'b1;
                    if (is_trap) begin
                        pc_q    <= bus.trap_vector;
                        flush_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (is_trap) begin
                        pc_q    <= bus.trap_vector;
                        flush_q <= 1'b1;
                    end else if (is_jump && target_misaligned) begin
                        state      <= FAULT;
                        misalign_q <= 1'b1;
                        fault_q    <= 1'b1;
                        pc_valid_q <= 1'b0;
                    end else if (is_jump) begin
                        pc_q    <= target;
                        flush_q <= 1'b1;
                    end else if (!bus.stall && bus.fetch_ready) begin
                        pc_q <= pc_q + XLEN'(4);
                    end
                end
                FAULT: begin
                    if (is_trap) begin
                        state      <= RUN;
                        pc_q       <= bus.trap_vector;
                        flush_q    <= 1'b1;
                        fault_q    <= 1'b0;
                        pc_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= BOOT;
                    pc_valid_q <= 1'b0;
                    fault_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid   = pc_valid_q;
    assign bus.flush_o    = flush_q;
    assign bus.misalign_o = misalign_q;
    assign bus.fault_o    = fault_q;

`ifdef PC_GEN_RAS_EN
    localparam int unsigned    PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned    CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W-1:0] ras_ptr_nxt;
    logic [PTR_W-1:0] ras_ptr_dec;
    logic [PTR_W-1:0] ras_wr_ptr;
    logic [CNT_W-1:0] ras_cnt;
    logic [CNT_W-1:0] ras_cnt_nxt;
    logic [XLEN-1:0]  ras_ret;
    logic [XLEN-1:0]  ras_top_q;
    logic [XLEN-1:0]  ras_top_nxt;
    logic             ras_empty_q;
    logic             do_push;
    logic             do_pop;

    // Stack updates are accepted only while running; a trap wins over both.
    assign do_push     = (state == RUN) && bus.ras_push && !is_trap;
    assign do_pop      = (state == RUN) && bus.ras_pop && !is_trap;
    assign ras_ret     = bus.ex_pc + XLEN'(4);
    assign ras_ptr_dec = ras_ptr - PTR_W'(1);

    // Next pointer, occupancy and top-of-stack value.  A push always lands one
    // slot above the top, which on a full stack is the oldest entry.
    always_comb begin
        ras_ptr_nxt = ras_ptr;
        ras_cnt_nxt = ras_cnt;
        ras_wr_ptr  = ras_ptr + PTR_W'(1);
        ras_top_nxt = ras_top_q;
        if (is_trap) begin
            ras_cnt_nxt = '0;
            ras_top_nxt = '0;
        end else if (do_push && do_pop) begin
            ras_wr_ptr = ras_ptr;
            if (ras_cnt != '0) begin
                ras_top_nxt = ras_ret;
            end
        end else if (do_push) begin
            ras_ptr_nxt = ras_ptr + PTR_W'(1);
            ras_top_nxt = ras_ret;
            if (ras_cnt != CNT_FULL) begin
                ras_cnt_nxt = ras_cnt + CNT_W'(1);
            end
        end else if (do_pop && (ras_cnt != '0)) begin
            ras_ptr_nxt = ras_ptr_dec;
            ras_cnt_nxt = ras_cnt - CNT_W'(1);
            ras_top_nxt = (ras_cnt == CNT_W'(1)) ? '0 : ras_mem[ras_ptr_dec];
        end
    end

    // RAS pointer, occupancy and registered top/empty outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr     <= '0;
            ras_cnt     <= '0;
            ras_top_q   <= '0;
            ras_empty_q <= 1'b1;
        end else begin
            ras_ptr     <= ras_ptr_nxt;
            ras_cnt     <= ras_cnt_nxt;
            ras_top_q   <= ras_top_nxt;
            ras_empty_q <= (ras_cnt_nxt == '0);
        end
    end

    // Return-address storage.
    // NOTE: the storage array has no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[ras_wr_ptr] <= ras_ret;
        end
    end

    assign bus.ras_top   = ras_top_q;
    assign bus.ras_empty = ras_empty_q;
`else
    logic unused_ras;
    assign unused_ras    = ^{bus.ras_push, bus.ras_pop, RAS_DEPTH[0]};
    assign bus.ras_top   = '0;
    assign bus.ras_empty = 1'b1;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen (RESET_VECTOR=0x100, RAS_DEPTH=4).
// A behavioural model tracks the expected outputs from the block's rules;
// a negedge compare process checks every output each cycle, and directed
// steps add hand-computed literal checks.
module tb_pc_gen;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RV   = 32'h100;
    localparam int unsigned DEPTH = 4;
`ifdef PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic check_en;
    int   n_vec;
    int   n_err;

    pc_gen_if #(.XLEN(XLEN)) bus ();

    pc_gen #(
        .XLEN        (XLEN),
        .RESET_VECTOR(RV),
        .RAS_DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    bit          m_booting;
    bit          m_running;
    bit          m_faulted;
    bit          m_flush;
    bit          m_mis;
    logic [31:0] m_ras[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc      = RV;
            m_booting = 1'b1;
            m_running = 1'b0;
            m_faulted = 1'b0;
            m_flush   = 1'b0;
            m_mis     = 1'b0;
            m_ras.delete();
        end else begin
            bit          trap;
            bit          jump;
            logic [31:0] tgt;
            trap = bus.redirect_valid && bus.redirect_src == 2'd3;
            jump = bus.redirect_valid && (bus.redirect_src == 2'd1 || bus.redirect_src == 2'd2);
            if (bus.redirect_src == 2'd1) tgt = bus.ex_pc + bus.imm;
            else                          tgt = (bus.rs1_data + bus.imm) & ~32'd1;

            // return-address stack, judged on the pre-edge mode
            if (RAS_ON) begin
                if (trap) begin
                    m_ras.delete();
                end else if (m_running && bus.ras_push && bus.ras_pop) begin
                    if (m_ras.size() > 0) m_ras[m_ras.size()-1] = bus.ex_pc + 32'd4;
                end else if (m_running && bus.ras_push) begin
                    if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(bus.ex_pc + 32'd4);
                end else if (m_running && bus.ras_pop) begin
                    if (m_ras.size() > 0) void'(m_ras.pop_back());
                end
            end

            m_flush = 1'b0;
            m_mis   = 1'b0;
            if (m_booting) begin
                m_booting = 1'b0;
                m_running = 1'b1;
                if (trap) begin m_pc = bus.trap_vector; m_flush = 1'b1; end
            end else if (m_faulted) begin
                if (trap) begin
                    m_pc = bus.trap_vector; m_flush = 1'b1;
                    m_faulted = 1'b0; m_running = 1'b1;
                end
            end else begin
                if (trap) begin
                    m_pc = bus.trap_vector; m_flush = 1'b1;
                end else if (jump) begin
                    if (tgt % 4 != 0) begin
                        m_mis = 1'b1; m_faulted = 1'b1; m_running = 1'b0;
                    end else begin
                        m_pc = tgt; m_flush = 1'b1;
                    end
                end else if (!bus.stall && bus.fetch_ready) begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            check("pc_o",       bus.pc_o,             m_pc);
            check("pc_valid",   32'(bus.pc_valid),    32'(m_running));
            check("flush_o",    32'(bus.flush_o),     32'(m_flush));
            check("misalign_o", 32'(bus.misalign_o),  32'(m_mis));
            check("fault_o",    32'(bus.fault_o),     32'(m_faulted));
            check("ras_top",    bus.ras_top,          (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0);
            check("ras_empty",  32'(bus.ras_empty),   32'(m_ras.size() == 0));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.redirect_valid = 1'b0;
        bus.redirect_src   = 2'd0;
        bus.stall          = 1'b0;
        bus.ras_push       = 1'b0;
        bus.ras_pop        = 1'b0;
    endtask

    task automatic trap_to(input logic [31:0] tv);
        bus.redirect_valid = 1'b1;
        bus.redirect_src   = 2'd3;
        bus.trap_vector    = tv;
    endtask

    logic [31:0] exp_top;

    initial begin
        n_vec = 0;
        n_err = 0;
        check_en = 1'b1;
        rst_n = 1'b0;
        bus.fetch_ready = 1'b0;
        bus.ex_pc = '0; bus.imm = '0; bus.rs1_data = '0; bus.trap_vector = '0;
        quiet();

        // reset state
        tick();
        check("rst pc_o", bus.pc_o, 32'h100);
        check("rst pc_valid", 32'(bus.pc_valid), 32'd0);
        check("rst fault_o", 32'(bus.fault_o), 32'd0);
        check("rst ras_top", bus.ras_top, 32'h0);
        check("rst ras_empty", 32'(bus.ras_empty), 32'd1);
        rst_n = 1'b1;
        bus.fetch_ready = 1'b1;

        // boot bubble, then sequential fetch
        tick(); check("boot pc 100", bus.pc_o, 32'h100);
        check("boot valid", 32'(bus.pc_valid), 32'd1);
        tick(); check("seq pc 104", bus.pc_o, 32'h104);
        tick(); check("seq pc 108", bus.pc_o, 32'h108);

        // branch redirect beats stall
        bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_src = 2'd1;
        bus.ex_pc = 32'h200; bus.imm = 32'hFFFF_FFF0;
        tick(); check("branch pc", bus.pc_o, 32'h1F0);
        check("branch flush", 32'(bus.flush_o), 32'd1);
        quiet();
        tick(); check("flush ends", 32'(bus.flush_o), 32'd0);
        check("after branch pc", bus.pc_o, 32'h1F4);

        // src 00 is not a redirect
        bus.redirect_valid = 1'b1; bus.redirect_src = 2'd0;
        tick(); check("src00 pc", bus.pc_o, 32'h1F8);
        check("src00 flush", 32'(bus.flush_o), 32'd0);

        // JALR clears bit0
        bus.redirect_src = 2'd2; bus.rs1_data = 32'h301; bus.imm = 32'h0;
        tick(); check("jalr pc", bus.pc_o, 32'h300);

        // misaligned JALR -> FAULT
        bus.rs1_data = 32'h302;
        tick(); check("mis pulse", 32'(bus.misalign_o), 32'd1);
        check("mis fault", 32'(bus.fault_o), 32'd1);
        check("mis valid", 32'(bus.pc_valid), 32'd0);
        check("mis pc held", bus.pc_o, 32'h300);
        check("mis no flush", 32'(bus.flush_o), 32'd0);

        // FAULT ignores an aligned non-trap redirect
        bus.redirect_src = 2'd1; bus.ex_pc = 32'h0; bus.imm = 32'h1000;
        tick(); check("fault hold pc", bus.pc_o, 32'h300);
        check("mis one cycle", 32'(bus.misalign_o), 32'd0);
        check("fault level", 32'(bus.fault_o), 32'd1);

        // trap leaves FAULT
        trap_to(32'h80);
        tick(); check("trap pc", bus.pc_o, 32'h80);
        check("trap fault clr", 32'(bus.fault_o), 32'd0);
        check("trap flush", 32'(bus.flush_o), 32'd1);

        // wrap at the top of the address space
        trap_to(32'hFFFF_FFFC);
        tick(); check("pre-wrap pc", bus.pc_o, 32'hFFFF_FFFC);
        quiet();
        tick(); check("wrap pc", bus.pc_o, 32'h0);

        // misaligned branch (odd target) then recover
        bus.redirect_valid = 1'b1; bus.redirect_src = 2'd1;
        bus.ex_pc = 32'h10; bus.imm = 32'h1;
        tick(); check("odd branch fault", 32'(bus.fault_o), 32'd1);
        trap_to(32'h200);
        tick(); check("recover pc", bus.pc_o, 32'h200);
        quiet();

        // asynchronous reset mid-operation, then trap honoured in BOOT
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async rst pc", bus.pc_o, 32'h100);
        check("async rst valid", 32'(bus.pc_valid), 32'd0);
        check("async rst flush", 32'(bus.flush_o), 32'd0);
        tick();
        trap_to(32'h40);
        rst_n = 1'b1;
        tick(); check("boot trap pc", bus.pc_o, 32'h40);
        check("boot trap flush", 32'(bus.flush_o), 32'd1);
        check("boot trap valid", 32'(bus.pc_valid), 32'd1);
        quiet();
        bus.fetch_ready = 1'b0;

        // RAS: five pushes into four entries
        bus.ras_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.ex_pc = 32'(i * 16);
            tick();
        end
        bus.ras_push = 1'b0;
        exp_top = RAS_ON ? 32'h44 : 32'h0;
        check("ras 5 push top", bus.ras_top, exp_top);
        bus.ras_pop = 1'b1;
        tick(); exp_top = RAS_ON ? 32'h34 : 32'h0; check("ras pop1", bus.ras_top, exp_top);
        tick(); exp_top = RAS_ON ? 32'h24 : 32'h0; check("ras pop2", bus.ras_top, exp_top);
        tick(); exp_top = RAS_ON ? 32'h14 : 32'h0; check("ras pop3", bus.ras_top, exp_top);
        tick(); check("ras pop4 empty", 32'(bus.ras_empty), 32'd1);
        tick(); check("ras pop on empty", bus.ras_top, 32'h0);
        bus.ras_pop = 1'b0;

        // push+pop replaces the top without changing occupancy
        bus.ras_push = 1'b1;
        bus.ex_pc = 32'h60; tick();
        bus.ex_pc = 32'h70; tick();
        bus.ras_pop = 1'b1; bus.ex_pc = 32'h50;
        tick(); exp_top = RAS_ON ? 32'h54 : 32'h0; check("ras push+pop top", bus.ras_top, exp_top);
        bus.ras_push = 1'b0;
        tick(); exp_top = RAS_ON ? 32'h64 : 32'h0; check("ras below top", bus.ras_top, exp_top);
        check("ras still full-ish", 32'(bus.ras_empty), 32'(!RAS_ON));

        // trap with a simultaneous push clears the stack
        bus.ras_pop = 1'b0; bus.ras_push = 1'b1; bus.ex_pc = 32'h90;
        trap_to(32'h500);
        tick(); check("ras trap empty", 32'(bus.ras_empty), 32'd1);
        check("ras trap top", bus.ras_top, 32'h0);
        check("ras trap pc", bus.pc_o, 32'h500);
        quiet();
        tick();

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
